// File: rtl/store_merge_rmw.sv
// Sub-word store unit: read-modify-write of the aligned memory word, with a direct write for full-width stores.
// Define STORE_MERGE_ALIGN_CHECK_EN to reject misaligned stores; otherwise the offset is truncated to the store size.
module store_merge_rmw #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam logic [5:0] LANES6 = 6'(LANES);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;

  state_t            state;
  logic [DATA_W-1:0] wdata_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic [2:0]        cnt;

  logic [4:0]        req_bytes;
  logic [OFF_W-1:0]  req_off, size_mask, trunc_off;
  logic              oversize, full_width, misaligned;
  logic [ADDR_W-1:0] aligned_addr;

  logic [15:0]       q_m16;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] bit_mask, shifted, merged;

  always_comb begin
    req_bytes    = 5'd1 << req_size;
    req_off      = req_addr[OFF_W-1:0];
    size_mask    = OFF_W'(req_bytes - 5'd1);
    trunc_off    = req_off & ~size_mask;
    oversize     = {1'b0, req_bytes} > LANES6;
    full_width   = {1'b0, req_bytes} == LANES6;
    aligned_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  assign misaligned = |(req_off & size_mask);
`else
  assign misaligned = 1'b0;
`endif

  // Lane mask covers 2^size lanes starting at the latched offset; other lanes keep memory data.
  always_comb begin
    q_m16     = (16'h1 << (5'd1 << size_q)) - 16'h1;
    lane_mask = LANES'(q_m16) << off_q;
    bit_mask  = '0;
    for (int k = 0; k < LANES; k++) bit_mask[8*k +: 8] = {8{lane_mask[k]}};
    shifted   = wdata_q << {off_q, 3'b000};
    merged    = (mem_rdata & ~bit_mask) | (shifted & bit_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      size_q    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          wdata_q   <= req_wdata;
          off_q     <= trunc_off;
          size_q    <= req_size;
          if (oversize || misaligned) begin
            state <= ERR;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (full_width) begin
            state     <= WRITE;
            mem_wr    <= 1'b1;
            mem_addr  <= aligned_addr;
            mem_wdata <= req_wdata;
          end else begin
            state    <= READ;
            mem_rd   <= 1'b1;
            mem_addr <= aligned_addr;
          end
        end
        READ: begin
          mem_rd <= 1'b0;
          cnt    <= 3'(MEM_LAT);
          state  <= WAIT;
        end
        // Read data is only valid on the edge that ends the last wait cycle.
        WAIT: begin
          if (cnt == 3'd1) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            state     <= WRITE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WRITE: begin
          mem_wr   <= 1'b0;
          mem_addr <= '0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE, ERR: begin
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_rmw.sv
// Randomised and directed bench for store_merge_rmw against a byte-lane memory model.
module tb_store_merge_rmw;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int MEM_LAT = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [logic [31:0]];
  logic        rd_pend = 1'b0;
  int          rd_age = 0;
  logic [31:0] rd_addr_q = '0;

  store_merge_rmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Memory returns data only in the cycle MEM_LAT after the read strobe; noise otherwise.
  always @(negedge clk) begin
    if (rd_pend) rd_age++;
    if (rd_pend && rd_age == MEM_LAT) begin
      mem_rdata = memRead(rd_addr_q);
      rd_pend = 1'b0;
    end else begin
      mem_rdata = $urandom;
    end
    if (mem_rd) begin
      rd_pend = 1'b1;
      rd_age = 0;
      rd_addr_q = mem_addr;
    end
    if (!reset_n) rd_pend = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    int n, o, exp_rd_c, exp_wr_c, exp_done_c;
    int rd_n, wr_n, rd_c, wr_c, done_c, cyc;
    logic exp_err, got_err, ready_bad, addr_bad;
    logic [31:0] base, exp_word, rd_a, wr_a, wr_d;
    n = 1 << size;
    o = int'(addr[1:0]);
    base = {addr[31:2], 2'b00};
    exp_err = (n > 4);
    if (!exp_err && (o % n) != 0) begin
`ifdef STORE_MERGE_ALIGN_CHECK_EN
      exp_err = 1'b1;
`else
      o = o - (o % n);
`endif
    end
    exp_word = memRead(base);
    if (!exp_err)
      for (int i = 0; i < n; i++) exp_word[8*(o+i) +: 8] = wdata[8*i +: 8];
    if (exp_err) begin
      exp_rd_c = 0; exp_wr_c = 0; exp_done_c = 1;
    end else if (n == 4) begin
      exp_rd_c = 0; exp_wr_c = 1; exp_done_c = 2;
    end else begin
      exp_rd_c = 1; exp_wr_c = 2 + MEM_LAT; exp_done_c = 3 + MEM_LAT;
    end

    checkOutput("ready_idle", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_size = size;
    rd_n = 0; wr_n = 0; rd_c = 0; wr_c = 0; done_c = 0; cyc = 0;
    rd_a = '0; wr_a = '0; wr_d = '0; got_err = 1'b0; ready_bad = 1'b0; addr_bad = 1'b0;
    while (done_c == 0 && cyc < 16) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'($urandom_range(0, 1));
      req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
      if (req_ready) ready_bad = 1'b1;
      if (mem_rd) begin rd_n++; rd_c = cyc; rd_a = mem_addr; end
      if (mem_wr) begin wr_n++; wr_c = cyc; wr_a = mem_addr; wr_d = mem_wdata; end
      if (done) begin
        done_c = cyc;
        got_err = err;
        if (mem_addr != 0) addr_bad = 1'b1;
      end
    end
    req_valid = 1'b0;

    checkOutput("done_cycle", 64'(done_c), 64'(exp_done_c));
    checkOutput("err", {63'b0, got_err}, {63'b0, exp_err});
    checkOutput("rd_count", 64'(rd_n), (exp_rd_c != 0) ? 64'd1 : 64'd0);
    checkOutput("wr_count", 64'(wr_n), (exp_wr_c != 0) ? 64'd1 : 64'd0);
    checkOutput("ready_busy", {63'b0, ready_bad}, 64'd0);
    checkOutput("addr_at_done", {63'b0, addr_bad}, 64'd0);
    if (exp_rd_c != 0) begin
      checkOutput("rd_cycle", 64'(rd_c), 64'(exp_rd_c));
      checkOutput("rd_addr", {32'b0, rd_a}, {32'b0, base});
    end
    if (exp_wr_c != 0) begin
      checkOutput("wr_cycle", 64'(wr_c), 64'(exp_wr_c));
      checkOutput("wr_addr", {32'b0, wr_a}, {32'b0, base});
      checkOutput("wr_data", {32'b0, wr_d}, {32'b0, exp_word});
      mem[base] = exp_word;
    end

    @(negedge clk);
    checkOutput("done_clear", {63'b0, done}, 64'd0);
    checkOutput("ready_back", {63'b0, req_ready}, 64'd1);
    if (done_c == 0) begin
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic resetDuringWait();
    logic bad;
    mem[32'h100] = 32'hAABBCCDD;
    req_valid = 1'b1; req_addr = 32'h103; req_wdata = 32'h55; req_size = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("rst_wr", {63'b0, mem_wr}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    checkOutput("rst_addr", {32'b0, mem_addr}, 64'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr || done || mem_rd) bad = 1'b1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr || done || mem_rd) bad = 1'b1;
    end
    checkOutput("rst_quiet", {63'b0, bad}, 64'd0);
    applyStimulus(32'h102, 32'h11, 2'b00);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("reset_rd", {63'b0, mem_rd}, 64'd0);
    checkOutput("reset_wr", {63'b0, mem_wr}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    checkOutput("reset_err", {63'b0, err}, 64'd0);
    checkOutput("reset_addr", {32'b0, mem_addr}, 64'd0);
    checkOutput("reset_wdata", {32'b0, mem_wdata}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    mem[32'h100] = 32'hAABBCCDD;
    applyStimulus(32'h102, 32'h11, 2'b00);
    checkOutput("plan_byte", {32'b0, mem[32'h100]}, 64'hAA11CCDD);
    mem[32'h100] = 32'hAABBCCDD;
    applyStimulus(32'h100, 32'h2233, 2'b01);
    checkOutput("plan_half", {32'b0, mem[32'h100]}, 64'hAABB2233);
    applyStimulus(32'h104, 32'hDEADBEEF, 2'b10);
    checkOutput("plan_word", {32'b0, mem[32'h104]}, 64'hDEADBEEF);
    mem[32'h100] = 32'hAABBCCDD;
    applyStimulus(32'h101, 32'h2233, 2'b01);
    applyStimulus(32'h100, 32'h12345678, 2'b11);
    resetDuringWait();

    for (int t = 0; t < 60; t++) begin
      applyStimulus(32'h100 + 32'($urandom_range(0, 31)), $urandom, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checkOutput("gap_ready", {63'b0, req_ready}, 64'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
